// File: rtl/count_snapshot_fifo.sv
// Snapshot FIFO for the free-running counter: captures are tagged with a wrap flag and drained FWFT.
// Optional define CNT_SNAP_DROP_CNT_EN adds a saturating drop_count output.
module count_snapshot_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] count_in,
  input  logic              capture,
  output logic [DATA_W:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              clr_ovf
`ifdef CNT_SNAP_DROP_CNT_EN
  ,
  output logic [7:0]        drop_count
`endif
);

  localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_LVL  = (ADDR_W+1)'(1);
  localparam logic [DATA_W-1:0] CNT_MAX  = {DATA_W{1'b1}};

  logic [DATA_W:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_nxt;
  logic [ADDR_W:0]   level_nxt;
  logic [DATA_W-1:0] prev_count;
  logic              wrap_pending;
  logic              wrap_now;
  logic              pop;
  logic              wr_en;
  logic              drop;
  logic              head_bypass;
  logic [DATA_W:0]   wr_entry;
  logic [DATA_W:0]   head_nxt;

`ifdef CNT_SNAP_DROP_CNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  always_comb begin
    pop      = out_valid && out_ready;
    wrap_now = (prev_count == CNT_MAX) && (count_in == '0);
    wr_en    = capture && (!full || pop);
    drop     = capture && full && !pop;
    wr_entry = {wrap_pending | wrap_now, count_in};
    rd_nxt   = pop ? rd_ptr + ADDR_W'(1) : rd_ptr;

    level_nxt = level;
    if (wr_en && !pop)
      level_nxt = level + ONE_LVL;
    else if (!wr_en && pop)
      level_nxt = level - ONE_LVL;

    // A write landing in an otherwise empty FIFO becomes the head directly.
    head_bypass = wr_en && (level_nxt == ONE_LVL);
    head_nxt    = head_bypass ? wr_entry : mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      out_valid    <= 1'b0;
      out_data     <= '0;
      overflow     <= 1'b0;
      prev_count   <= '0;
      wrap_pending <= 1'b0;
    end else begin
      prev_count <= count_in;
      if (wr_en)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      rd_ptr    <= rd_nxt;
      level     <= level_nxt;
      full      <= (level_nxt == FULL_LVL);
      empty     <= (level_nxt == '0);
      out_valid <= (level_nxt != '0);
      if (level_nxt != '0)
        out_data <= head_nxt;

      // A dropped capture keeps its pending wrap for the next accepted one.
      if (wr_en)
        wrap_pending <= 1'b0;
      else if (wrap_now)
        wrap_pending <= 1'b1;

      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

`ifdef CNT_SNAP_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      drop_count <= 8'd0;
    else if (clr_ovf)
      drop_count <= drop ? 8'd1 : 8'd0;
    else if (drop)
      drop_count <= sat_inc(drop_count);
  end
`endif

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Scoreboard bench for count_snapshot_fifo; follows CNT_SNAP_DROP_CNT_EN like the design.
module tb_count_snapshot_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] count_in = 4'h0;
  logic       capture = 1'b0;
  logic [4:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       full;
  logic       empty;
  logic [3:0] level;
  logic       overflow;
  logic       clr_ovf = 1'b0;
`ifdef CNT_SNAP_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [4:0] q[$];
  logic [3:0] m_prev = 4'h0;
  bit         m_pend = 1'b0;
  bit         m_ovf = 1'b0;
  logic [7:0] m_drop = 8'd0;

  count_snapshot_fifo #(.DATA_W(4), .DEPTH(DEPTH), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .capture(capture),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .clr_ovf(clr_ovf)
`ifdef CNT_SNAP_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle, advance the reference model, sample 1 ns after the edge.
  task automatic cycle(input bit cap, input logic [3:0] cnt, input bit rdy, input bit clr);
    bit pop, wr, drp, wrap, full_m;
    @(negedge clk);
    rst = 1'b0; capture = cap; count_in = cnt; out_ready = rdy; clr_ovf = clr;
    full_m = (q.size() == DEPTH);
    pop    = (q.size() != 0) && rdy;
    wrap   = (m_prev == 4'hF) && (cnt == 4'h0);
    wr     = cap && (!full_m || pop);
    drp    = cap && full_m && !pop;
    if (pop) void'(q.pop_front());
    if (wr) q.push_back({m_pend | wrap, cnt});
    m_pend = wr ? 1'b0 : (m_pend | wrap);
    if (drp) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (clr) m_drop = drp ? 8'd1 : 8'd0;
    else if (drp && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
    m_prev = cnt;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; capture = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    q.delete(); m_prev = 4'h0; m_pend = 1'b0; m_ovf = 1'b0; m_drop = 8'd0;
  endtask

  task automatic test_reset();
    do_reset(2);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_single();
    cycle(1'b1, 4'h5, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 5'b0_0101) begin errors++; $display("FAIL single_data: got %b want 00101", out_data); end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL single_level: got %0d want 1", level); end
    cycle(1'b0, 4'h5, 1'b0, 1'b0);
    checks++; if (out_data !== q[0]) begin errors++; $display("FAIL single_hold: got %b want %b", out_data, q[0]); end
    cycle(1'b0, 4'h5, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: empty %b valid %b want 1 0", empty, out_valid); end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 4'hE, 1'b0, 1'b0);
    cycle(1'b0, 4'hF, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    cycle(1'b1, 4'h1, 1'b0, 1'b0);
    checks++; if (out_data !== 5'b1_0001) begin errors++; $display("FAIL wrap_flag: got %b want 10001", out_data); end
    cycle(1'b0, 4'h2, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 1'b1, 1'b0);
    checks++; if (out_data !== 5'b0_0011) begin errors++; $display("FAIL wrap_clear: got %b want 00011", out_data); end
    cycle(1'b0, 4'h3, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_drain: empty %b want 1", empty); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
    checks++; if (full !== 1'b1 || level !== 4'd8) begin errors++; $display("FAIL fill_full: full %b level %0d want 1 8", full, level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early: got %b want 0", overflow); end
    cycle(1'b1, 4'h8, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1 || level !== 4'd8) begin errors++; $display("FAIL drop_ovf: ovf %b level %0d want 1 8", overflow, level); end
`ifdef CNT_SNAP_DROP_CNT_EN
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL drop_cnt1: got %0d want 1", drop_count); end
`endif
    cycle(1'b1, 4'h8, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_vs_drop: got %b want 1", overflow); end
`ifdef CNT_SNAP_DROP_CNT_EN
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL clr_drop_cnt: got %0d want 1", drop_count); end
`endif
    cycle(1'b0, 4'h8, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b want 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== {1'b0, 4'(i)} || q.size() == 0 || out_data !== q[0]) begin
        errors++; $display("FAIL drain_%0d: valid %b data %b want %b", i, out_valid, out_data, {1'b0, 4'(i)});
      end
      cycle(1'b0, 4'h8, 1'b1, 1'b0);
    end
    checks++; if (empty !== 1'b1 || level !== 4'd0) begin errors++; $display("FAIL drain_empty: empty %b level %0d", empty, level); end
  endtask

  task automatic test_simul_full();
    int exp_seq [8] = '{1, 2, 3, 4, 5, 6, 7, 9};
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
    cycle(1'b1, 4'h9, 1'b1, 1'b0);
    checks++; if (level !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL simul_level: level %0d full %b want 8 1", level, full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_ovf: got %b want 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== {1'b0, 4'(exp_seq[i])}) begin
        errors++; $display("FAIL simul_drain_%0d: valid %b data %b want %b", i, out_valid, out_data, {1'b0, 4'(exp_seq[i])});
      end
      cycle(1'b0, 4'h9, 1'b1, 1'b0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty: got %b want 1", empty); end
  endtask

  task automatic test_mid_reset();
    cycle(1'b1, 4'h1, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    cycle(1'b0, 4'hF, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    do_reset(1);
    checks++; if (level !== 4'd0 || out_valid !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL midrst_state: level %0d valid %b empty %b want 0 0 1", level, out_valid, empty);
    end
    cycle(1'b1, 4'hA, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 5'b0_1010) begin errors++; $display("FAIL midrst_data: got %b want 01010", out_data); end
    cycle(1'b0, 4'hA, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] cnt = 4'h0;
    for (int i = 0; i < 120; i++) begin
      cnt = cnt + 4'h1;
      cycle(1'($urandom_range(0, 1)), cnt, (i < 60) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
      checks++;
      if (level !== 4'(q.size()) || out_valid !== (q.size() != 0) || full !== (q.size() == DEPTH) ||
          empty !== (q.size() == 0) || overflow !== m_ovf) begin
        errors++; $display("FAIL b2b_status_%0d: level %0d valid %b ovf %b want %0d %b", i, level, out_valid, overflow, q.size(), m_ovf);
      end
      if (q.size() != 0) begin
        checks++;
        if (out_data !== q[0]) begin errors++; $display("FAIL b2b_data_%0d: got %b want %b", i, out_data, q[0]); end
      end
`ifdef CNT_SNAP_DROP_CNT_EN
      checks++;
      if (drop_count !== m_drop) begin errors++; $display("FAIL b2b_dropcnt_%0d: got %0d want %0d", i, drop_count, m_drop); end
`endif
    end
  endtask

`ifdef CNT_SNAP_DROP_CNT_EN
  task automatic test_drop_sat();
    cycle(1'b0, 4'h1, 1'b0, 1'b1);
    while (q.size() < DEPTH) cycle(1'b1, 4'h1, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) cycle(1'b1, 4'h1, 1'b0, 1'b0);
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d want 255", drop_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_fill_overflow();
    test_simul_full();
    test_mid_reset();
    test_back_to_back();
`ifdef CNT_SNAP_DROP_CNT_EN
    test_drop_sat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
